// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR MAC sequencer: stores each accepted sample in a circular delay line,
// walks the registered coefficient ROM one tap per cycle and emits full-precision y[n].
//
// state | meaning
// IDLE  | waiting for an input sample (s_ready_o=1)
// MAC   | issuing one coefficient address + delayed sample per cycle, accumulating
// DRAIN | no more issues; flushing the ROM pipeline into the accumulator
// OUT   | result held on m_data_o until downstream accepts it
module fir_mac_seq #(
   parameter  int DATA_WIDTH = 16,
   parameter  int COEF_WIDTH = 16,
   parameter  int TAP_NUM    = 32,
   localparam int ADDR_WIDTH = $clog2(TAP_NUM),
   localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [ADDR_WIDTH-1:0] coef_addr_o,
   input  logic [COEF_WIDTH-1:0] coef_data_i,
   output logic [ACC_WIDTH-1:0]  m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i
);

   localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(TAP_NUM - 1);

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] line [TAP_NUM];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] k;
   logic [DATA_WIDTH-1:0] samp_q;
   logic [DATA_WIDTH-1:0] samp_d;
   logic                  iss_v;
   logic                  rd_v;
   logic [ACC_WIDTH-1:0]  acc;

   logic [PROD_WIDTH-1:0] samp_ext;
   logic [PROD_WIDTH-1:0] coef_ext;
   logic [PROD_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [ACC_WIDTH-1:0]  acc_sum;

   // The ROM answers one edge after the address, so the sample is delayed by one
   // extra register (samp_d) to meet its coefficient; rd_v marks a live pair.
   assign samp_ext = {{COEF_WIDTH{samp_d[DATA_WIDTH-1]}}, samp_d};
   assign coef_ext = {{DATA_WIDTH{coef_data_i[COEF_WIDTH-1]}}, coef_data_i};
   assign prod     = samp_ext * coef_ext;
   assign prod_ext = {{ADDR_WIDTH{prod[PROD_WIDTH-1]}}, prod};
   assign acc_sum  = acc + prod_ext;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         for (int i = 0; i < TAP_NUM; i++) line[i] <= '0;
         wr_ptr      <= '0;
         k           <= '0;
         samp_q      <= '0;
         samp_d      <= '0;
         iss_v       <= 1'b0;
         rd_v        <= 1'b0;
         acc         <= '0;
         coef_addr_o <= '0;
         m_data_o    <= '0;
         m_valid_o   <= 1'b0;
         s_ready_o   <= 1'b1;
      end else begin
         rd_v   <= iss_v;
         samp_d <= samp_q;
         case (state)
            IDLE: begin
               if (s_valid_i && s_ready_o) begin
                  line[wr_ptr] <= s_data_i;
                  acc          <= '0;
                  k            <= '0;
                  iss_v        <= 1'b0;
                  s_ready_o    <= 1'b0;
                  state        <= MAC;
               end
            end
            MAC: begin
               coef_addr_o <= k;
               samp_q      <= line[wr_ptr - k];
               iss_v       <= 1'b1;
               if (rd_v) acc <= acc_sum;
               k <= k + 1'b1;
               if (k == K_LAST) state <= DRAIN;
            end
            DRAIN: begin
               iss_v <= 1'b0;
               if (iss_v) begin
                  acc <= acc_sum;
               end else begin
                  m_data_o  <= acc_sum;
                  m_valid_o <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (m_ready_i) begin
                  m_valid_o <= 1'b0;
                  wr_ptr    <= wr_ptr + 1'b1;
                  s_ready_o <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: convolution model over a shifted history, ROM model with 1-cycle read,
// directed impulse/DC/extreme/backpressure/reset tests and a random stream.
module tb_fir_mac_seq;

   localparam int DW = 16, CW = 16, TN = 32, AW = 5, ACCW = 37;
   localparam longint BAD = 64'sh7fff_ffff_ffff_ffff;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [DW-1:0]   s_data_i = '0;
   logic            s_valid_i = 1'b0;
   logic            s_ready_o;
   logic [AW-1:0]   coef_addr_o;
   logic [CW-1:0]   coef_data_i = '0;
   logic [ACCW-1:0] m_data_o;
   logic            m_valid_o;
   logic            m_ready_i = 1'b0;

   fir_mac_seq #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAP_NUM(TN)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .coef_addr_o(coef_addr_o), .coef_data_i(coef_data_i),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
   );

   always #5 clk_i = ~clk_i;

   logic signed [CW-1:0] rom [TN];
   always @(posedge clk_i) coef_data_i <= rom[coef_addr_o];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // reference model: y[n] = sum h[k] * x[n-k], history zero after reset
   logic signed [DW-1:0] hist [TN];
   longint exp_q[$];
   longint got[$];
   int     out_cnt = 0;

   function automatic longint conv();
      longint s = 0;
      for (int i = 0; i < TN; i++) s += longint'(hist[i]) * longint'(rom[i]);
      return s;
   endfunction

   function automatic longint got_at(int i);
      if (i < got.size()) return got[i];
      return BAD;
   endfunction

   int cyc = 0;
   always @(posedge clk_i) cyc++;

   int              hs_cyc = 0;
   bit              hs_active = 0;
   bit              prev_v = 0;
   logic [ACCW-1:0] prev_data = '0;
   logic [AW-1:0]   prev_addr = '0;

   always @(negedge clk_i) begin
      if (rst_i) begin
         exp_q.delete();
         for (int i = 0; i < TN; i++) hist[i] = '0;
         hs_active = 0;
         prev_v    = 0;
      end else begin
         if (hs_active && (cyc - hs_cyc) >= 1 && (cyc - hs_cyc) <= TN)
            check("coef_addr_seq", longint'(coef_addr_o), longint'(cyc - hs_cyc - 1));
         if (m_valid_o) begin
            check("valid_has_pending", longint'(exp_q.size() > 0), 1);
            check("s_ready_in_out", longint'(s_ready_o), 0);
            if (!prev_v) begin
               if (hs_active) check("latency", longint'(cyc - hs_cyc), TN + 2);
               hs_active = 0;
            end else begin
               check("m_data_hold", longint'(m_data_o), longint'(prev_data));
               check("coef_addr_hold", longint'(coef_addr_o), longint'(prev_addr));
            end
            if (m_ready_i && exp_q.size() > 0) begin
               check("y", longint'($signed(m_data_o)), exp_q.pop_front());
               got.push_back(longint'($signed(m_data_o)));
               out_cnt++;
            end
         end
         if (s_valid_i && s_ready_o) begin
            for (int i = TN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = $signed(s_data_i);
            exp_q.push_back(conv());
            hs_cyc    = cyc + 1;
            hs_active = 1;
         end
         prev_v    = m_valid_o;
         prev_data = m_data_o;
         prev_addr = coef_addr_o;
      end
   end

   int rdy_pct = 100;
   always begin
      @(posedge clk_i);
      #1;
      m_ready_i = ($urandom_range(99) < rdy_pct);
   end

   task automatic feed(input logic [DW-1:0] x, input int pv);
      bit done = 0;
      bit acc;
      if (pv < 100) repeat ($urandom_range(3)) begin @(posedge clk_i); #1; end
      s_data_i  = x;
      s_valid_i = 1'b1;
      for (int t = 0; t < 2000 && !done; t++) begin
         @(negedge clk_i);
         acc = s_valid_i && s_ready_o && !rst_i;
         @(posedge clk_i);
         #1;
         if (acc) done = 1;
      end
      s_valid_i = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL feed_timeout: sample %0d not accepted", $signed(x));
      end
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int t = 0; t < 5000 && !done; t++) begin
         if (exp_q.size() == 0 && s_ready_o && !m_valid_o) done = 1;
         else begin @(posedge clk_i); #1; end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle_timeout: %0d results still pending", exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      s_valid_i = 1'b0;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic impulse_run(input string tag);
      int base = got.size();
      feed(16'd1, 100);
      for (int i = 0; i < 40; i++) feed(16'd0, 100);
      wait_idle();
      check({tag, "_y0"},  got_at(base + 0), 1);
      check({tag, "_y15"}, got_at(base + 15), 16);
      check({tag, "_y31"}, got_at(base + 31), 32);
      check({tag, "_y32"}, got_at(base + 32), 0);
      check({tag, "_y40"}, got_at(base + 40), 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n0;
      bit seen;

      for (int i = 0; i < TN; i++) rom[i] = 16'(i + 1);

      repeat (2) @(posedge clk_i);
      #1;
      check("rst_s_ready", longint'(s_ready_o), 1);
      check("rst_m_valid", longint'(m_valid_o), 0);
      check("rst_m_data", longint'(m_data_o), 0);
      check("rst_coef_addr", longint'(coef_addr_o), 0);
      rst_i = 1'b0;

      impulse_run("imp");

      // backpressure: result held 10 cycles while a second sample waits
      do_reset();
      base = got.size();
      rdy_pct = 0;
      feed(16'd5, 100);
      s_data_i  = 16'd7;
      s_valid_i = 1'b1;
      seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(posedge clk_i);
         #1;
         seen = m_valid_o;
      end
      check("bp_valid_seen", longint'(seen), 1);
      n0 = out_cnt;
      repeat (10) begin @(posedge clk_i); #1; end
      check("bp_still_valid", longint'(m_valid_o), 1);
      check("bp_no_transfer", longint'(out_cnt), longint'(n0));
      check("bp_s_ready", longint'(s_ready_o), 0);
      rdy_pct = 100;
      feed(16'd7, 100);
      wait_idle();
      check("bp_out_count", longint'(out_cnt), longint'(n0 + 2));
      check("bp_y0", got_at(base + 0), 5);
      check("bp_y1", got_at(base + 1), 17);

      // DC input crosses the write-pointer wrap
      do_reset();
      base = got.size();
      for (int i = 0; i < 40; i++) feed(16'd1, 100);
      wait_idle();
      check("dc_y0", got_at(base + 0), 1);
      check("dc_y1", got_at(base + 1), 3);
      check("dc_y30", got_at(base + 30), 496);
      check("dc_y31", got_at(base + 31), 528);
      check("dc_y39", got_at(base + 39), 528);

      // extreme negative operands
      do_reset();
      for (int i = 0; i < TN; i++) rom[i] = 16'sh8000;
      base = got.size();
      for (int i = 0; i < 40; i++) feed(16'h8000, 100);
      wait_idle();
      check("ext_y0", got_at(base + 0), 64'd1073741824);
      check("ext_y31", got_at(base + 31), 64'd34359738368);
      check("ext_y39", got_at(base + 39), 64'd34359738368);
      for (int i = 0; i < TN; i++) rom[i] = 16'(i + 1);

      // reset in the middle of a computation
      do_reset();
      feed(16'd3, 100);
      repeat (15) @(posedge clk_i);
      #1;
      check("mid_addr_busy", longint'(coef_addr_o), 14);
      rst_i = 1'b1;
      #1;
      check("mid_rst_m_valid", longint'(m_valid_o), 0);
      check("mid_rst_s_ready", longint'(s_ready_o), 1);
      check("mid_rst_coef_addr", longint'(coef_addr_o), 0);
      check("mid_rst_m_data", longint'(m_data_o), 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      n0 = out_cnt;
      repeat (50) begin @(posedge clk_i); #1; end
      check("mid_no_output", longint'(out_cnt), longint'(n0));
      impulse_run("rimp");

      // random coefficients, samples and handshakes
      do_reset();
      for (int i = 0; i < TN; i++) rom[i] = 16'($urandom);
      n0 = out_cnt;
      rdy_pct = 50;
      for (int i = 0; i < 200; i++) feed(16'($urandom), 60);
      wait_idle();
      rdy_pct = 100;
      check("rand_out_count", longint'(out_cnt), longint'(n0 + 200));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
